// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage feeding the MIPS control unit.
// Holds the PC, fetches one word per req/ack handshake, presents the
// latched instruction and its opcode, computes sequential or beq-taken
// next PC, holds under stall and raises a sticky fault on fetch timeout.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic [15:0] branch_imm_i,
    output logic [31:0] instr_o,
    output logic [5:0]  opcode_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    // Word-aligned reset PC: the low two address bits are always zero.
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    // The wait counter holds the number of REQ cycles already spent without
    // an ack, so it only ever needs to reach TIMEOUT-1.
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       pc_seq;
    logic [31:0]       branch_off;
    logic [31:0]       pc_next;

    // Next-PC arithmetic: sequential, or beq-taken with sign-extended word offset.
    always_comb begin
        pc_seq     = pc_q + 32'd4;
        branch_off = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};
        pc_next    = (branch_i && zero_i) ? (pc_seq + branch_off) : pc_seq;
    end

    // State, PC, instruction and wait-counter registers with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_INIT;
            instr_q <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; an ack takes priority over the timeout in the last REQ cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack_i) begin
                    instr_d = imem_data_i;
                    cnt_d   = '0;
                    state_d = ST_VALID;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_VALID: begin
                if (!stall_i) begin
                    pc_d    = pc_next;
                    state_d = ST_REQ;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the registered state so reset clears them at once.
    always_comb begin
        imem_req_o    = (state_q == ST_REQ);
        instr_valid_o = (state_q == ST_VALID);
        fault_o       = (state_q == ST_FAULT);
        imem_addr_o   = pc_q;
        pc_o          = pc_q;
        instr_o       = instr_q;
        opcode_o      = instr_q[31:26];
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed testbench for mips_fetch_unit (RESET_PC=0, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        branch_i;
    logic        zero_i;
    logic [15:0] branch_imm_i;
    logic [31:0] instr_o;
    logic [5:0]  opcode_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic        fault_o;

    int compared;
    int mismatched;

    mips_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .zero_i        (zero_i),
        .branch_imm_i  (branch_imm_i),
        .instr_o       (instr_o),
        .opcode_o      (opcode_o),
        .instr_valid_o (instr_valid_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        imem_ack_i   = 1'b0;
        imem_data_i  = 32'd0;
        stall_i      = 1'b0;
        branch_i     = 1'b0;
        zero_i       = 1'b0;
        branch_imm_i = 16'd0;
        tick();
        tick();
        compared++; if (pc_o !== 32'd0) begin mismatched++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'd0); end
        compared++; if (imem_addr_o !== 32'd0) begin mismatched++; $display("FAIL reset_addr: got %h expected %h", imem_addr_o, 32'd0); end
        compared++; if (instr_o !== 32'd0) begin mismatched++; $display("FAIL reset_instr: got %h expected %h", instr_o, 32'd0); end
        compared++; if (opcode_o !== 6'd0) begin mismatched++; $display("FAIL reset_opcode: got %0d expected 0", opcode_o); end
        compared++; if ({imem_req_o, instr_valid_o, fault_o} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b expected 000", {imem_req_o, instr_valid_o, fault_o}); end
        rst_n = 1'b1;
        tick();
        // Second cycle after release: first request to address 0.
        compared++; if (imem_req_o !== 1'b1) begin mismatched++; $display("FAIL first_req: got %b expected 1", imem_req_o); end
        compared++; if (imem_addr_o !== 32'd0) begin mismatched++; $display("FAIL first_addr: got %h expected %h", imem_addr_o, 32'd0); end
        imem_ack_i  = 1'b1;
        imem_data_i = 32'h8C00_0000;
        tick();
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h", 32'd0, 32'h8C00_0000);
        compared++; if (instr_valid_o !== 1'b1) begin mismatched++; $display("FAIL first_valid: got %b expected 1", instr_valid_o); end
        compared++; if (imem_req_o !== 1'b0) begin mismatched++; $display("FAIL first_req_low: got %b expected 0", imem_req_o); end
        compared++; if (opcode_o !== 6'd35) begin mismatched++; $display("FAIL first_opcode: got %0d expected 35", opcode_o); end
        compared++; if (instr_o !== 32'h8C00_0000) begin mismatched++; $display("FAIL first_instr: got %h expected %h", instr_o, 32'h8C00_0000); end
        compared++; if (pc_o !== 32'd0) begin mismatched++; $display("FAIL first_pc: got %h expected %h", pc_o, 32'd0); end
    endtask

    task automatic test_free_run();
        logic [31:0] data_tab [3];
        data_tab[0] = 32'h2002_0001;
        data_tab[1] = 32'h0043_2020;
        data_tab[2] = 32'hAC05_0008;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (imem_req_o !== 1'b1 || instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL run_req[%0d]: got req=%b valid=%b expected req=1 valid=0", i, imem_req_o, instr_valid_o); end
            compared++; if (imem_addr_o !== 32'(4 * (i + 1))) begin mismatched++; $display("FAIL run_addr[%0d]: got %h expected %h", i, imem_addr_o, 32'(4 * (i + 1))); end
            imem_ack_i  = 1'b1;
            imem_data_i = data_tab[i];
            tick();
            imem_ack_i = 1'b0;
            $display("fetch addr=%h data=%h", 32'(4 * (i + 1)), data_tab[i]);
            compared++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin mismatched++; $display("FAIL run_valid[%0d]: got valid=%b req=%b expected valid=1 req=0", i, instr_valid_o, imem_req_o); end
            compared++; if (instr_o !== data_tab[i]) begin mismatched++; $display("FAIL run_instr[%0d]: got %h expected %h", i, instr_o, data_tab[i]); end
        end
    endtask

    task automatic test_wait_states();
        tick();
        for (int k = 0; k < 4; k++) begin
            compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL wait_hold[%0d]: got req=%b addr=%h valid=%b expected req=1 addr=00000010 valid=0", k, imem_req_o, imem_addr_o, instr_valid_o); end
            if (k == 3) begin
                imem_ack_i  = 1'b1;
                imem_data_i = 32'h1000_FFFE;
            end
            tick();
        end
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h waits=3", 32'h10, 32'h1000_FFFE);
        compared++; if (instr_valid_o !== 1'b1) begin mismatched++; $display("FAIL wait_valid: got %b expected 1", instr_valid_o); end
        compared++; if (instr_o !== 32'h1000_FFFE || opcode_o !== 6'd4) begin mismatched++; $display("FAIL wait_instr: got %h/%0d expected 1000fffe/4", instr_o, opcode_o); end
    endtask

    task automatic test_branch();
        // Taken: 0x10 + 4 + (-2 << 2) = 0x0C.
        branch_i = 1'b1; zero_i = 1'b1; branch_imm_i = 16'hFFFE;
        tick();
        branch_i = 1'b0; zero_i = 1'b0; branch_imm_i = 16'h0000;
        compared++; if (imem_addr_o !== 32'h0C) begin mismatched++; $display("FAIL br_taken: got %h expected %h", imem_addr_o, 32'h0C); end
        imem_ack_i = 1'b1; imem_data_i = 32'h0000_0020;
        tick();
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h", 32'h0C, 32'h0000_0020);
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'h1000_FFFE;
        tick();
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h", 32'h10, 32'h1000_FFFE);
        compared++; if (pc_o !== 32'h10) begin mismatched++; $display("FAIL br_setup_pc: got %h expected %h", pc_o, 32'h10); end
        // Not taken: Zero=0 gives 0x14.
        branch_i = 1'b1; zero_i = 1'b0; branch_imm_i = 16'hFFFE;
        tick();
        branch_i = 1'b0; branch_imm_i = 16'h0000;
        compared++; if (imem_addr_o !== 32'h14) begin mismatched++; $display("FAIL br_not_taken: got %h expected %h", imem_addr_o, 32'h14); end
        imem_ack_i = 1'b1; imem_data_i = 32'h1000_FFF9;
        tick();
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h", 32'h14, 32'h1000_FFF9);
        // Taken backwards past zero: 0x14 + 4 + (-7 << 2) = 0xFFFF_FFFC.
        branch_i = 1'b1; zero_i = 1'b1; branch_imm_i = 16'hFFF9;
        tick();
        branch_i = 1'b0; zero_i = 1'b0; branch_imm_i = 16'h0000;
        compared++; if (imem_addr_o !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL br_wrap_target: got %h expected %h", imem_addr_o, 32'hFFFF_FFFC); end
        imem_ack_i = 1'b1; imem_data_i = 32'h0000_0000;
        tick();
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h", 32'hFFFF_FFFC, 32'h0);
        tick();
        compared++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin mismatched++; $display("FAIL pc_wrap: got addr=%h req=%b expected 00000000 req=1", imem_addr_o, imem_req_o); end
        imem_ack_i = 1'b1; imem_data_i = 32'h2001_0005;
        tick();
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h", 32'h0, 32'h2001_0005);
    endtask

    task automatic test_stall();
        tick();
        compared++; if (imem_addr_o !== 32'h4) begin mismatched++; $display("FAIL stall_pre_addr: got %h expected %h", imem_addr_o, 32'h4); end
        // Stall rises together with the ack so it is high as InstrValid rises.
        stall_i = 1'b1; imem_ack_i = 1'b1; imem_data_i = 32'h8C22_0010;
        tick();
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h stalled", 32'h4, 32'h8C22_0010);
        for (int k = 0; k < 5; k++) begin
            compared++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== 32'h4 || instr_o !== 32'h8C22_0010) begin mismatched++; $display("FAIL stall_hold[%0d]: got valid=%b req=%b pc=%h instr=%h expected 1 0 00000004 8c220010", k, instr_valid_o, imem_req_o, pc_o, instr_o); end
            tick();
        end
        stall_i = 1'b0;
        tick();
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin mismatched++; $display("FAIL stall_release: got req=%b addr=%h expected req=1 addr=00000008", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 8; k++) begin
            compared++; if (imem_req_o !== 1'b1 || fault_o !== 1'b0) begin mismatched++; $display("FAIL to_req[%0d]: got req=%b fault=%b expected req=1 fault=0", k, imem_req_o, fault_o); end
            tick();
        end
        $display("fetch addr=%h timed out", 32'h8);
        compared++; if (fault_o !== 1'b1 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL to_fault: got fault=%b req=%b valid=%b expected 1 0 0", fault_o, imem_req_o, instr_valid_o); end
        imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF;
        tick();
        tick();
        imem_ack_i = 1'b0;
        compared++; if (fault_o !== 1'b1 || instr_valid_o !== 1'b0 || instr_o !== 32'h8C22_0010) begin mismatched++; $display("FAIL to_sticky: got fault=%b valid=%b instr=%h expected 1 0 8c220010", fault_o, instr_valid_o, instr_o); end
        rst_n = 1'b0;
        #1;
        compared++; if (fault_o !== 1'b0 || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin mismatched++; $display("FAIL to_reset: got fault=%b pc=%h req=%b expected 0 00000000 0", fault_o, pc_o, imem_req_o); end
        tick();
        rst_n = 1'b1;
        tick();
        // Ack exactly in the 8th REQ cycle beats the timeout.
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                imem_ack_i = 1'b1; imem_data_i = 32'h3C01_1234;
            end
            tick();
        end
        imem_ack_i = 1'b0;
        $display("fetch addr=%h data=%h waits=7", 32'h0, 32'h3C01_1234);
        compared++; if (instr_valid_o !== 1'b1 || fault_o !== 1'b0 || instr_o !== 32'h3C01_1234) begin mismatched++; $display("FAIL to_last_ack: got valid=%b fault=%b instr=%h expected 1 0 3c011234", instr_valid_o, fault_o, instr_o); end
        tick();
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin mismatched++; $display("FAIL to_next_req: got req=%b addr=%h expected 1 00000004", imem_req_o, imem_addr_o); end
        // Reset mid-REQ drops the request without a clock edge.
        rst_n = 1'b0;
        #1;
        compared++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || instr_o !== 32'h0) begin mismatched++; $display("FAIL mid_req_reset: got req=%b addr=%h instr=%h expected 0 00000000 00000000", imem_req_o, imem_addr_o, instr_o); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_free_run();
        test_wait_states();
        test_branch();
        test_stall();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
